rf_wb_arbiter: RTL and testbench

Writeback arbiter and pending-write scoreboard in front of the single write port of the 32x32 register file. Two producers compete for that port: the ALU/execute result path and the load/memory result path. The block grants them round-robin with a valid/ready handshake and drives the register-file write port from a registered stage. It also keeps a per-register busy bit so issue logic can detect RAW hazards against in-flight writes.

---
 rtl/rf_pkg.sv | 19 +
 rtl/rf_scoreboard.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 95 +++++++++
 tb/tb_rf_wb_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry constants, writeback request record
// and the writeback source encoding used by the arbiter's priority pointer.
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write bits. A completing write clears its bit, a new
// reservation sets one; when both hit the same register the reservation wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  output logic [2**ADDR_W-1:0]   busy
);

  logic [2**ADDR_W-1:0] busy_next;

  // Set is applied after clear so the younger producer keeps the register busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) begin
      busy_next[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != '0)) begin
      busy_next[set_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback arbiter between the ALU and load paths feeding the single
// register-file write port, with a pending-write scoreboard and contention counter.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_W-1:0]     alu_addr,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic                  rsv_valid,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_wr_addr,
  output logic [DATA_W-1:0]     rf_wr_data,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [15:0]           conflict_cnt
);

  wb_src_e ptr;
  logic    alu_fire;
  logic    mem_fire;
  logic    any_fire;
  wb_req_t winner;

  // Ready ignores the requester's own valid so producers can rely on it upfront.
  assign alu_ready = !mem_valid || (ptr == WB_ALU);
  assign mem_ready = !alu_valid || (ptr == WB_MEM);
  assign alu_fire  = alu_valid && alu_ready;
  assign mem_fire  = mem_valid && mem_ready;
  assign any_fire  = alu_fire || mem_fire;

  always_comb begin
    winner.addr = alu_addr;
    winner.data = alu_data;
    if (mem_fire) begin
      winner.addr = mem_addr;
      winner.data = mem_data;
    end
  end

  // Pointer always hands priority to the side that did not just transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= WB_ALU;
    end else if (alu_fire) begin
      ptr <= WB_MEM;
    end else if (mem_fire) begin
      ptr <= WB_ALU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
    end else if (any_fire) begin
      rf_we      <= (winner.addr != '0);
      rf_wr_addr <= winner.addr;
      rf_wr_data <= winner.data;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (alu_valid && mem_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr_en   (rf_we),
    .clr_addr (rf_wr_addr),
    .set_en   (rsv_valid),
    .set_addr (rsv_addr),
    .busy     (busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a vector table for arbitration, x0 and
// scoreboard behaviour, plus sequences for async reset and counter saturation.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid, mem_valid, rsv_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_addr, mem_addr, rsv_addr;
  logic [31:0] alu_data, mem_data;
  logic        rf_we;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [31:0] busy;
  logic [15:0] conflict_cnt;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic        rv;
    logic [4:0]  ra;
    logic        e_ar;
    logic        e_mr;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  rf_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .rf_we        (rf_we),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .busy         (busy),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
    mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
    rsv_valid = v.rv; rsv_addr = v.ra;
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //            av aa  ad            mv ma  md            rv ra  ar mr we addr  data          busy          cnt
    vecs[0]  = '{1, 3, 32'h11,       1, 7, 32'h22,       0, 0, 1, 0, 1, 3, 32'h11,       32'h0,   16'd1};
    vecs[1]  = '{1, 3, 32'h11,       1, 7, 32'h22,       0, 0, 0, 1, 1, 7, 32'h22,       32'h0,   16'd2};
    vecs[2]  = '{1, 3, 32'h11,       1, 7, 32'h22,       0, 0, 1, 0, 1, 3, 32'h11,       32'h0,   16'd3};
    vecs[3]  = '{1, 3, 32'h11,       1, 7, 32'h22,       0, 0, 0, 1, 1, 7, 32'h22,       32'h0,   16'd4};
    vecs[4]  = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 7, 32'h22,       32'h0,   16'd4};
    vecs[5]  = '{0, 0, 32'h0,        1, 5, 32'hA5A50001, 0, 0, 1, 1, 1, 5, 32'hA5A50001, 32'h0,   16'd4};
    vecs[6]  = '{0, 0, 32'h0,        1, 5, 32'hA5A50002, 0, 0, 1, 1, 1, 5, 32'hA5A50002, 32'h0,   16'd4};
    vecs[7]  = '{0, 0, 32'h0,        1, 5, 32'hA5A50003, 0, 0, 1, 1, 1, 5, 32'hA5A50003, 32'h0,   16'd4};
    vecs[8]  = '{1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 32'hFFFFFFFF, 32'h0,   16'd4};
    vecs[9]  = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 1, 1, 0, 0, 32'hFFFFFFFF, 32'h200, 16'd4};
    vecs[10] = '{1, 9, 32'h99,       0, 0, 32'h0,        0, 0, 1, 1, 1, 9, 32'h99,       32'h200, 16'd4};
    vecs[11] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 9, 32'h99,       32'h0,   16'd4};
    vecs[12] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 1, 1, 0, 9, 32'h99,       32'h200, 16'd4};
    vecs[13] = '{1, 9, 32'h9A,       0, 0, 32'h0,        0, 0, 1, 1, 1, 9, 32'h9A,       32'h200, 16'd4};
    vecs[14] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 9, 1, 1, 0, 9, 32'h9A,       32'h200, 16'd4};
    vecs[15] = '{0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1, 1, 0, 9, 32'h9A,       32'h200, 16'd4};
    vecs[16] = '{0, 0, 32'h0,        0, 0, 32'h0,        1, 0, 1, 1, 0, 9, 32'h9A,       32'h200, 16'd4};

    idle();
    rst = 1'b1;
    #12;
    checkOutput("reset_we",   {31'd0, rf_we}, 32'd0);
    checkOutput("reset_addr", {27'd0, rf_wr_addr}, 32'd0);
    checkOutput("reset_data", rf_wr_data, 32'd0);
    checkOutput("reset_busy", busy, 32'd0);
    checkOutput("reset_cnt",  {16'd0, conflict_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].e_ar});
      checkOutput($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, vecs[i].e_mr});
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d_we", i),   {31'd0, rf_we}, {31'd0, vecs[i].e_we});
      checkOutput($sformatf("v%0d_addr", i), {27'd0, rf_wr_addr}, {27'd0, vecs[i].e_addr});
      checkOutput($sformatf("v%0d_data", i), rf_wr_data, vecs[i].e_data);
      checkOutput($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      checkOutput($sformatf("v%0d_cnt", i),  {16'd0, conflict_cnt}, {16'd0, vecs[i].e_cnt});
      @(negedge clk);
    end

    // Mid-stream async reset: pointer is at MEM after the last ALU grant, busy[9] is set.
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h44;
    mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h66;
    rsv_valid = 1'b0; rsv_addr = '0;
    @(posedge clk);
    #1;
    checkOutput("pre_rst_we",   {31'd0, rf_we}, 32'd1);
    checkOutput("pre_rst_addr", {27'd0, rf_wr_addr}, 32'd6);
    checkOutput("pre_rst_cnt",  {16'd0, conflict_cnt}, 32'd5);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_we",   {31'd0, rf_we}, 32'd0);
    checkOutput("async_rst_busy", busy, 32'd0);
    checkOutput("async_rst_cnt",  {16'd0, conflict_cnt}, 32'd0);
    checkOutput("async_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
    checkOutput("async_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_first_grant", {27'd0, rf_wr_addr}, 32'd4);
    checkOutput("post_rst_first_data", rf_wr_data, 32'h44);

    // Keep both requests asserted well past the 16-bit limit.
    for (int c = 0; c < 65540; c++) begin
      @(posedge clk);
    end
    #1;
    checkOutput("sat_cnt", {16'd0, conflict_cnt}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    checkOutput("sat_hold", {16'd0, conflict_cnt}, 32'h0000FFFF);

    idle();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
